// File: rtl/map_pkg.sv
// Shared definitions for the map RAM: geometry, cell codes, arbiter states.
package map_pkg;

    localparam int MAP_COLS = 40;
    localparam int MAP_ROWS = 30;
    localparam int CELL_W   = 4;
    localparam int ROW_W    = 160;

    localparam logic [3:0] BG     = 4'h0;
    localparam logic [3:0] WALL   = 4'h1;
    localparam logic [3:0] PILL   = 4'h2;
    localparam logic [3:0] PACMAN = 4'h3;
    localparam logic [3:0] GHOST1 = 4'h4;
    localparam logic [3:0] GHOST2 = 4'h5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_SRC,
        ST_WAIT_SRC,
        ST_WR_SRC,
        ST_RD_DST,
        ST_WAIT_DST,
        ST_WR_DST,
        ST_DONE
    } arb_state_t;

    // Column 0 lives in the most significant nibble of a row.
    function automatic logic [7:0] cell_lsb(input logic [5:0] x);
        return 8'(ROW_W - CELL_W) - {x, 2'b00};
    endfunction

endpackage

// File: rtl/map_cell_merge.sv
// Replaces one cell of a map row and reports what the cell held before.
module map_cell_merge
    import map_pkg::*;
(
    input  logic [ROW_W-1:0]  row_in,
    input  logic [5:0]        x,
    input  logic [CELL_W-1:0] cell_code,
    output logic [ROW_W-1:0]  row_out,
    output logic [CELL_W-1:0] old_cell
);

    // Columns past the right edge leave the row untouched.
    always_comb begin
        row_out  = row_in;
        old_cell = '0;
        if (int'(x) < MAP_COLS) begin
            old_cell                          = row_in[cell_lsb(x) +: CELL_W];
            row_out[cell_lsb(x) +: CELL_W]    = cell_code;
        end
    end

endmodule

// File: rtl/map_port_arbiter.sv
// Round-robin owner of map RAM port B: each granted move clears the source
// cell, then writes the sprite code into the destination cell.
module map_port_arbiter
    import map_pkg::*;
#(
    parameter int         NREQ    = 3,
    parameter int         RD_LAT  = 2,
    parameter logic [3:0] BG_CODE = 4'h0
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*6-1:0] cur_x,
    input  logic [NREQ*5-1:0] cur_y,
    input  logic [NREQ*6-1:0] nxt_x,
    input  logic [NREQ*5-1:0] nxt_y,
    input  logic [NREQ*4-1:0] code,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic [3:0]        hit_code,
    output logic              busy,
    output logic [4:0]        ram_addr,
    output logic [159:0]      ram_wrdata,
    output logic              ram_wren,
    input  logic [159:0]      ram_rddata
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [CNT_W-1:0] wait_cnt;
    logic [5:0]       cur_x_l;
    logic [4:0]       cur_y_l;
    logic [5:0]       nxt_x_l;
    logic [4:0]       nxt_y_l;
    logic [3:0]       code_l;
    logic [3:0]       hit_l;

    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic [5:0]       sel_cur_x;
    logic [4:0]       sel_cur_y;
    logic [5:0]       sel_nxt_x;
    logic [4:0]       sel_nxt_y;
    logic [3:0]       sel_code;
    logic             sel_bad;

    logic [5:0]       merge_x;
    logic [3:0]       merge_code;
    logic [159:0]     merge_row;
    logic [3:0]       merge_old;

    // Pick the first requester at or after the round-robin pointer.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Steer the winning requester's operands and range-check them.
    always_comb begin
        sel_cur_x = '0;
        sel_cur_y = '0;
        sel_nxt_x = '0;
        sel_nxt_y = '0;
        sel_code  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_cur_x = cur_x[i*6 +: 6];
                sel_cur_y = cur_y[i*5 +: 5];
                sel_nxt_x = nxt_x[i*6 +: 6];
                sel_nxt_y = nxt_y[i*5 +: 5];
                sel_code  = code[i*4 +: 4];
            end
        end
        sel_bad = (int'(sel_cur_x) >= MAP_COLS) || (int'(sel_nxt_x) >= MAP_COLS) ||
                  (int'(sel_cur_y) >= MAP_ROWS) || (int'(sel_nxt_y) >= MAP_ROWS);
    end

    // One merge unit shared by both passes: clear the source, then place the code.
    always_comb begin
        merge_x    = (state == ST_WAIT_DST) ? nxt_x_l : cur_x_l;
        merge_code = (state == ST_WAIT_DST) ? code_l  : BG_CODE;
    end

    map_cell_merge u_merge (
        .row_in    (ram_rddata),
        .x         (merge_x),
        .cell_code (merge_code),
        .row_out   (merge_row),
        .old_cell  (merge_old)
    );

    // Move sequencer; every output is registered on entry to the state it belongs to.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            winner     <= '0;
            wait_cnt   <= '0;
            cur_x_l    <= '0;
            cur_y_l    <= '0;
            nxt_x_l    <= '0;
            nxt_y_l    <= '0;
            code_l     <= '0;
            hit_l      <= '0;
            done       <= '0;
            err        <= 1'b0;
            hit_code   <= '0;
            busy       <= 1'b0;
            ram_addr   <= '0;
            ram_wrdata <= '0;
            ram_wren   <= 1'b0;
        end else begin
            done     <= '0;
            ram_wren <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        winner  <= grant_idx;
                        cur_x_l <= sel_cur_x;
                        cur_y_l <= sel_cur_y;
                        nxt_x_l <= sel_nxt_x;
                        nxt_y_l <= sel_nxt_y;
                        code_l  <= sel_code;
                        rr_ptr  <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
                        busy    <= 1'b1;
                        if (sel_bad) begin
                            state           <= ST_DONE;
                            done[grant_idx] <= 1'b1;
                            err             <= 1'b1;
                            hit_code        <= '0;
                        end else begin
                            state    <= ST_RD_SRC;
                            ram_addr <= sel_cur_y;
                        end
                    end
                end
                ST_RD_SRC: begin
                    state    <= ST_WAIT_SRC;
                    wait_cnt <= '0;
                end
                ST_WAIT_SRC: begin
                    if (wait_cnt == CNT_W'(RD_LAT - 1)) begin
                        state      <= ST_WR_SRC;
                        ram_wrdata <= merge_row;
                        ram_wren   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_WR_SRC: begin
                    state    <= ST_RD_DST;
                    ram_addr <= nxt_y_l;
                end
                ST_RD_DST: begin
                    state    <= ST_WAIT_DST;
                    wait_cnt <= '0;
                end
                ST_WAIT_DST: begin
                    if (wait_cnt == CNT_W'(RD_LAT - 1)) begin
                        state      <= ST_WR_DST;
                        ram_wrdata <= merge_row;
                        hit_l      <= merge_old;
                        ram_wren   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_WR_DST: begin
                    state        <= ST_DONE;
                    done[winner] <= 1'b1;
                    err          <= 1'b0;
                    hit_code     <= hit_l;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_map_port_arbiter.sv
// Scoreboard bench for map_port_arbiter with a behavioural two-cycle-latency map RAM.
module tb_map_port_arbiter;

    localparam logic [3:0] C_BG     = 4'h0;
    localparam logic [3:0] C_WALL   = 4'h1;
    localparam logic [3:0] C_PILL   = 4'h2;
    localparam logic [3:0] C_PACMAN = 4'h3;
    localparam logic [3:0] C_GHOST1 = 4'h4;
    localparam logic [3:0] C_GHOST2 = 4'h5;

    logic         CLOCK_50;
    logic         reset_n;
    logic [2:0]   req;
    logic [17:0]  cur_x;
    logic [14:0]  cur_y;
    logic [17:0]  nxt_x;
    logic [14:0]  nxt_y;
    logic [11:0]  code;
    logic [2:0]   done;
    logic         err;
    logic [3:0]   hit_code;
    logic         busy;
    logic [4:0]   ram_addr;
    logic [159:0] ram_wrdata;
    logic         ram_wren;
    logic [159:0] ram_rddata;

    typedef struct {
        logic [2:0] vec;
        logic       err;
        logic [3:0] hit;
        int         cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           tests_run = 0;
    int           tests_failed = 0;
    int           cycle_cnt = 0;
    int           done_seen = 0;
    int           wren_cnt = 0;
    logic [159:0] mem [30];
    logic [159:0] snap [30];
    logic [159:0] rd_pipe1;
    logic [159:0] rd_pipe2;

    map_port_arbiter #(.NREQ(3), .RD_LAT(2), .BG_CODE(4'h0)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .req        (req),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .nxt_x      (nxt_x),
        .nxt_y      (nxt_y),
        .code       (code),
        .done       (done),
        .err        (err),
        .hit_code   (hit_code),
        .busy       (busy),
        .ram_addr   (ram_addr),
        .ram_wrdata (ram_wrdata),
        .ram_wren   (ram_wren),
        .ram_rddata (ram_rddata)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cycle_cnt <= cycle_cnt + 1;

    // Map RAM: synchronous write, read data two cycles after the address.
    always @(posedge CLOCK_50) begin
        if (ram_wren && ram_addr < 5'd30) mem[ram_addr] <= ram_wrdata;
        rd_pipe1 <= (ram_addr < 5'd30) ? mem[ram_addr] : '0;
        rd_pipe2 <= rd_pipe1;
    end
    assign ram_rddata = rd_pipe2;

    function automatic int lsb(input int x);
        return 156 - 4 * x;
    endfunction

    function automatic logic [3:0] get_cell(input int x, input int y);
        logic [159:0] row;
        row = mem[y];
        return row[lsb(x) +: 4];
    endfunction

    task automatic check_output(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge CLOCK_50) begin
        if (ram_wren) wren_cnt++;
        if (done != 3'b000) begin
            done_seen++;
            if (sb.size() == 0) begin
                check_output("unexpected_done", {157'b0, done}, 160'b0);
            end else begin
                mon_e = sb.pop_front();
                check_output("done_vec", {157'b0, done}, {157'b0, mon_e.vec});
                check_output("done_err", {159'b0, err}, {159'b0, mon_e.err});
                check_output("hit_code", {156'b0, hit_code}, {156'b0, mon_e.hit});
                check_output("done_cycle", 160'(cycle_cnt), 160'(mon_e.cyc));
            end
        end
    end

    task automatic preload(input int x, input int y, input logic [3:0] c);
        mem[y][lsb(x) +: 4] <= c;
        @(negedge CLOCK_50);
    endtask

    task automatic set_operands(input int idx, input int cx, input int cy,
                                input int nx, input int ny, input logic [3:0] cd);
        cur_x[idx*6 +: 6] = 6'(cx);
        cur_y[idx*5 +: 5] = 5'(cy);
        nxt_x[idx*6 +: 6] = 6'(nx);
        nxt_y[idx*5 +: 5] = 5'(ny);
        code[idx*4 +: 4]  = cd;
    endtask

    task automatic push_exp(input int idx, input logic e_err, input logic [3:0] e_hit, input int cyc);
        exp_t e;
        e.vec = 3'(1 << idx);
        e.err = e_err;
        e.hit = e_hit;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input int idx, input int cx, input int cy, input int nx, input int ny,
                                  input logic [3:0] cd, input logic e_err, input logic [3:0] e_hit,
                                  input int lat);
        @(negedge CLOCK_50);
        set_operands(idx, cx, cy, nx, ny, cd);
        req[idx] = 1'b1;
        push_exp(idx, e_err, e_hit, cycle_cnt + lat);
    endtask

    task automatic wait_done(input int target, input string name);
        for (int i = 0; i < 100; i++) begin
            if (done_seen >= target) break;
            @(negedge CLOCK_50);
            #2;
        end
        check_output(name, 160'(done_seen >= target), 160'd1);
    endtask

    task automatic reset_pulse();
        @(negedge CLOCK_50);
        reset_n = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (2) @(negedge CLOCK_50);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [159:0] exp_row;
        logic [159:0] row;
        int           base;
        int           diffs;

        reset_n = 1'b0;
        req     = '0;
        cur_x   = '0;
        cur_y   = '0;
        nxt_x   = '0;
        nxt_y   = '0;
        code    = '0;
        for (int r = 0; r < 30; r++) mem[r] <= '0;

        repeat (3) @(negedge CLOCK_50);
        #1;
        check_output("rst_done", {157'b0, done}, 160'b0);
        check_output("rst_err", {159'b0, err}, 160'b0);
        check_output("rst_hit", {156'b0, hit_code}, 160'b0);
        check_output("rst_busy", {159'b0, busy}, 160'b0);
        check_output("rst_wren", {159'b0, ram_wren}, 160'b0);
        check_output("rst_addr", {155'b0, ram_addr}, 160'b0);
        check_output("rst_wrdata", ram_wrdata, 160'b0);
        reset_n = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        check_output("idle_busy", {159'b0, busy}, 160'b0);
        check_output("idle_wren_cnt", 160'(wren_cnt), 160'd0);

        // Single move within row 3.
        preload(5, 3, C_PACMAN);
        preload(6, 3, C_PILL);
        preload(7, 3, C_WALL);
        wren_cnt = 0;
        base = done_seen;
        apply_stimulus(0, 5, 3, 6, 3, C_PACMAN, 1'b0, C_PILL, 9);
        wait_done(base + 1, "single_wait");
        req[0] = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        exp_row = '0;
        exp_row[lsb(6) +: 4] = C_PACMAN;
        exp_row[lsb(7) +: 4] = C_WALL;
        check_output("single_row3", mem[3], exp_row);
        check_output("single_wren_cnt", 160'(wren_cnt), 160'd2);

        // Contention after reset: order 0,1,2,0 ten cycles apart.
        reset_pulse();
        wren_cnt = 0;
        base = done_seen;
        @(negedge CLOCK_50);
        set_operands(0, 1, 1, 2, 1, C_PACMAN);
        set_operands(1, 1, 2, 2, 2, C_GHOST1);
        set_operands(2, 1, 4, 2, 4, C_GHOST2);
        req = 3'b111;
        push_exp(0, 1'b0, C_BG, cycle_cnt + 9);
        push_exp(1, 1'b0, C_BG, cycle_cnt + 19);
        push_exp(2, 1'b0, C_BG, cycle_cnt + 29);
        push_exp(0, 1'b0, C_PACMAN, cycle_cnt + 39);
        wait_done(base + 4, "contend_wait");
        req = 3'b000;
        repeat (3) @(negedge CLOCK_50);
        check_output("contend_wren_cnt", 160'(wren_cnt), 160'd8);
        check_output("contend_row1", {156'b0, get_cell(2, 1)}, {156'b0, C_PACMAN});
        check_output("contend_row2", {156'b0, get_cell(2, 2)}, {156'b0, C_GHOST1});
        check_output("contend_row4", {156'b0, get_cell(2, 4)}, {156'b0, C_GHOST2});

        // Out-of-range destination column: error, no writes.
        for (int r = 0; r < 30; r++) snap[r] = mem[r];
        wren_cnt = 0;
        base = done_seen;
        apply_stimulus(1, 3, 5, 40, 5, C_PACMAN, 1'b1, 4'h0, 1);
        wait_done(base + 1, "oor_wait");
        req[1] = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check_output("oor_wren_cnt", 160'(wren_cnt), 160'd0);
        diffs = 0;
        for (int r = 0; r < 30; r++) if (mem[r] !== snap[r]) diffs++;
        check_output("oor_mem_diffs", 160'(diffs), 160'd0);

        // Same source and destination cell.
        preload(10, 10, C_PILL);
        wren_cnt = 0;
        base = done_seen;
        apply_stimulus(2, 10, 10, 10, 10, C_GHOST1, 1'b0, C_BG, 9);
        wait_done(base + 1, "same_wait");
        req[2] = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check_output("same_cell", {156'b0, get_cell(10, 10)}, {156'b0, C_GHOST1});
        check_output("same_wren_cnt", 160'(wren_cnt), 160'd2);

        // Opposite corners on different rows.
        preload(0, 0, C_PACMAN);
        preload(39, 29, C_WALL);
        base = done_seen;
        apply_stimulus(0, 0, 0, 39, 29, C_GHOST2, 1'b0, C_WALL, 9);
        wait_done(base + 1, "corner_wait");
        req[0] = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        row = mem[0];
        check_output("corner_src", {156'b0, row[159:156]}, {156'b0, C_BG});
        row = mem[29];
        check_output("corner_dst", {156'b0, row[3:0]}, {156'b0, C_GHOST2});

        // Reset during the destination read wait.
        preload(20, 15, C_PACMAN);
        preload(21, 16, C_PILL);
        wren_cnt = 0;
        base = done_seen;
        @(negedge CLOCK_50);
        set_operands(0, 20, 15, 21, 16, C_PACMAN);
        req[0] = 1'b1;
        repeat (6) @(negedge CLOCK_50);
        #1;
        check_output("midrst_busy_before", {159'b0, busy}, 160'd1);
        check_output("midrst_wren_before", 160'(wren_cnt), 160'd1);
        reset_n = 1'b0;
        #1;
        check_output("midrst_wren", {159'b0, ram_wren}, 160'b0);
        check_output("midrst_busy", {159'b0, busy}, 160'b0);
        req[0] = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        check_output("midrst_done_cnt", 160'(done_seen), 160'(base));
        check_output("midrst_wren_after", 160'(wren_cnt), 160'd1);
        check_output("midrst_src", {156'b0, get_cell(20, 15)}, {156'b0, C_BG});
        check_output("midrst_dst", {156'b0, get_cell(21, 16)}, {156'b0, C_PILL});

        check_output("sb_empty", 160'(sb.size()), 160'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
